// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants, counter typedef and index range helper
package rf_pkg;
    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 2;
    localparam int DATA_W   = 32;

    typedef logic [CNT_W-1:0] cnt_arr_t [NUM_REGS];

    // 5-bit decode fields can name registers beyond the 16-entry file
    function automatic logic in_range(input logic [4:0] addr5);
        return 32'(addr5) < NUM_REGS;
    endfunction
endpackage

// File: rtl/reg_writeback_unit_if.sv
// rtl/reg_writeback_unit_if.sv - issue, hazard-check, MEM/WB and register-file write-port bundle
interface reg_writeback_unit_if #(
    parameter int DATA_W = 32
);
    logic              issue_valid;
    logic              issue_wr;
    logic [4:0]        issue_rd;
    logic              issue_ready;
    logic [4:0]        chk_rs;
    logic [4:0]        chk_rt;
    logic              hazard;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [DATA_W-1:0] wb_alu;
    logic [DATA_W-1:0] wb_mem;
    logic [4:0]        rd;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic              err;

    modport master (
        output issue_valid, issue_wr, issue_rd, chk_rs, chk_rt,
        output wb_valid, wb_rd, wb_reg_write, wb_mem_to_reg, wb_alu, wb_mem,
        input  issue_ready, hazard, rd, write_data, reg_write, err
    );

    modport slave (
        input  issue_valid, issue_wr, issue_rd, chk_rs, chk_rt,
        input  wb_valid, wb_rd, wb_reg_write, wb_mem_to_reg, wb_alu, wb_mem,
        output issue_ready, hazard, rd, write_data, reg_write, err
    );
endinterface

// File: rtl/reg_writeback_unit_wb_scoreboard.sv
// rtl/reg_writeback_unit_wb_scoreboard.sv - per-register pending-write counters and RAW hazard detect
module wb_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = rf_pkg::NUM_REGS,
    parameter int CNT_W    = rf_pkg::CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic       issue_wr,
    input  logic [4:0] issue_rd,
    output logic       issue_ready,
    input  logic [4:0] chk_rs,
    input  logic [4:0] chk_rt,
    output logic       hazard,
    input  logic       ret_valid,
    input  logic [4:0] ret_rd,
    output logic       err_set
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [IDX_W-1:0] iss_idx;
    logic [IDX_W-1:0] ret_idx;
    logic             issue_req;
    logic             inc_en;
    logic             dec_en;
    logic             underflow;

    function automatic logic pend(input logic [4:0] x);
        return in_range(x) && (x[IDX_W-1:0] != '0) && (cnt[x[IDX_W-1:0]] != '0);
    endfunction

    assign iss_idx = issue_rd[IDX_W-1:0];
    assign ret_idx = ret_rd[IDX_W-1:0];

    always_comb begin
        issue_req   = issue_valid & issue_wr;
        issue_ready = !(issue_req && (cnt[iss_idx] == CNT_MAX));
        inc_en      = issue_req && issue_ready && in_range(issue_rd) && (iss_idx != '0);
        dec_en      = ret_valid && in_range(ret_rd) && (ret_idx != '0);
        underflow   = dec_en && (cnt[ret_idx] == '0);
        err_set     = (issue_req && !in_range(issue_rd))
                    | (ret_valid && !in_range(ret_rd))
                    | underflow;
        hazard      = pend(chk_rs) | pend(chk_rt);
    end

    // An issue and a retire to the same register on one edge cancel out
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                cnt[i] <= '0;
            end else begin
                if (inc_en && (iss_idx == IDX_W'(i)) && !(dec_en && (ret_idx == IDX_W'(i)))) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec_en && (ret_idx == IDX_W'(i)) && !(inc_en && (iss_idx == IDX_W'(i)))
                             && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - MEM/WB register, write-back mux and sticky error around the scoreboard
module reg_writeback_unit
    import rf_pkg::*;
#(
    parameter int NUM_REGS = rf_pkg::NUM_REGS,
    parameter int DATA_W   = rf_pkg::DATA_W,
    parameter int CNT_W    = rf_pkg::CNT_W
) (
    input logic                 clk,
    input logic                 rst,
    reg_writeback_unit_if.slave bus
);
    logic              wb_take;
    logic              sb_err;
    logic [DATA_W-1:0] wb_value;

    assign wb_take  = bus.wb_valid & bus.wb_reg_write;
    assign wb_value = bus.wb_mem_to_reg ? bus.wb_mem : bus.wb_alu;

    wb_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (bus.issue_valid),
        .issue_wr    (bus.issue_wr),
        .issue_rd    (bus.issue_rd),
        .issue_ready (bus.issue_ready),
        .chk_rs      (bus.chk_rs),
        .chk_rt      (bus.chk_rt),
        .hazard      (bus.hazard),
        .ret_valid   (wb_take),
        .ret_rd      (bus.wb_rd),
        .err_set     (sb_err)
    );

    // rd/write_data hold between write-backs; only reg_write pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd         <= '0;
            bus.write_data <= '0;
            bus.reg_write  <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.err <= bus.err | sb_err;
            if (wb_take) begin
                bus.rd         <= bus.wb_rd;
                bus.write_data <= wb_value;
                bus.reg_write  <= in_range(bus.wb_rd) && (bus.wb_rd[IDX_W-1:0] != '0);
            end else begin
                bus.reg_write  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb/tb_reg_writeback_unit.sv - directed self-checking bench for reg_writeback_unit
module tb_reg_writeback_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_writeback_unit_if #(.DATA_W(32)) bus ();

    reg_writeback_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid   = 1'b0;
        bus.issue_wr      = 1'b0;
        bus.issue_rd      = 5'd0;
        bus.wb_valid      = 1'b0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_mem_to_reg = 1'b0;
        bus.wb_rd         = 5'd0;
        bus.wb_alu        = 32'h0;
        bus.wb_mem        = 32'h0;
    endtask

    task automatic issue(input logic [4:0] r);
        bus.issue_valid = 1'b1;
        bus.issue_wr    = 1'b1;
        bus.issue_rd    = r;
    endtask

    task automatic retire(input logic [4:0] r, input logic m2r, input logic [31:0] alu, input logic [31:0] mem);
        bus.wb_valid      = 1'b1;
        bus.wb_reg_write  = 1'b1;
        bus.wb_rd         = r;
        bus.wb_mem_to_reg = m2r;
        bus.wb_alu        = alu;
        bus.wb_mem        = mem;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.chk_rs = 5'd5;
        bus.chk_rt = 5'd0;
        do_reset();
        tick();
        total++; if (bus.rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", bus.rd); end
        total++; if (bus.write_data !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.write_data); end
        total++; if (bus.reg_write !== 1'b0) begin bad++; $display("FAIL reset_reg_write got=%b exp=0", bus.reg_write); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL reset_hazard got=%b exp=0", bus.hazard); end
    endtask

    task automatic test_basic();
        issue(5'd5);
        #1;
        total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", bus.issue_ready); end
        tick();
        idle();
        bus.chk_rs = 5'd5;
        #1;
        total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL basic_hazard_set got=%b exp=1", bus.hazard); end
        retire(5'd5, 1'b0, 32'h000000A0, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        total++; if (bus.rd !== 5'd5) begin bad++; $display("FAIL basic_rd got=%0d exp=5", bus.rd); end
        total++; if (bus.write_data !== 32'h000000A0) begin bad++; $display("FAIL basic_wdata got=%h exp=000000a0", bus.write_data); end
        total++; if (bus.reg_write !== 1'b1) begin bad++; $display("FAIL basic_reg_write got=%b exp=1", bus.reg_write); end
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL basic_hazard_clear got=%b exp=0", bus.hazard); end
        tick();
        total++; if (bus.reg_write !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", bus.reg_write); end
        total++; if (bus.rd !== 5'd5) begin bad++; $display("FAIL basic_rd_hold got=%0d exp=5", bus.rd); end
    endtask

    task automatic test_mem_select();
        issue(5'd7);
        tick();
        idle();
        retire(5'd7, 1'b1, 32'h11111111, 32'hBEFF556A);
        tick();
        idle();
        total++; if (bus.write_data !== 32'hBEFF556A) begin bad++; $display("FAIL mem_wdata got=%h exp=beff556a", bus.write_data); end
        total++; if (bus.rd !== 5'd7) begin bad++; $display("FAIL mem_rd got=%0d exp=7", bus.rd); end
        total++; if (bus.reg_write !== 1'b1) begin bad++; $display("FAIL mem_reg_write got=%b exp=1", bus.reg_write); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL mem_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_ready;
        exp_ready = 4'b0111;
        bus.chk_rs = 5'd3;
        for (int k = 0; k < 4; k++) begin
            issue(5'd3);
            #1;
            total++;
            if (bus.issue_ready !== exp_ready[k]) begin
                bad++; $display("FAIL sat_ready_%0d got=%b exp=%b", k, bus.issue_ready, exp_ready[k]);
            end
            tick();
        end
        idle();
        #1;
        total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL sat_hazard got=%b exp=1", bus.hazard); end
        for (int k = 0; k < 3; k++) begin
            retire(5'd3, 1'b0, 32'(k), 32'h0);
            tick();
            idle();
            #1;
            total++;
            if (bus.hazard !== (k < 2)) begin
                bad++; $display("FAIL sat_retire_%0d got=%b exp=%b", k, bus.hazard, (k < 2));
            end
        end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL sat_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_same_cycle();
        bus.chk_rs = 5'd0;
        bus.chk_rt = 5'd4;
        issue(5'd4);
        tick();
        issue(5'd4);
        retire(5'd4, 1'b0, 32'h44, 32'h0);
        tick();
        idle();
        #1;
        total++; if (bus.hazard !== 1'b1) begin bad++; $display("FAIL same_hazard got=%b exp=1", bus.hazard); end
        retire(5'd4, 1'b0, 32'h45, 32'h0);
        tick();
        idle();
        #1;
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL same_drain got=%b exp=0", bus.hazard); end
        bus.chk_rt = 5'd0;
        issue(5'd0);
        retire(5'd0, 1'b0, 32'h99, 32'h0);
        tick();
        idle();
        #1;
        total++; if (bus.reg_write !== 1'b0) begin bad++; $display("FAIL r0_reg_write got=%b exp=0", bus.reg_write); end
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL r0_hazard got=%b exp=0", bus.hazard); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL r0_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_errors();
        retire(5'd9, 1'b0, 32'h9, 32'h0);
        tick();
        idle();
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL underflow_err got=%b exp=1", bus.err); end
        tick();
        tick();
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", bus.err); end
        do_reset();
        issue(5'd20);
        #1;
        total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL oor_ready got=%b exp=1", bus.issue_ready); end
        tick();
        idle();
        bus.chk_rs = 5'd20;
        bus.chk_rt = 5'd4;
        #1;
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL oor_issue_err got=%b exp=1", bus.err); end
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL oor_issue_hazard got=%b exp=0", bus.hazard); end
        do_reset();
        retire(5'd17, 1'b0, 32'h17, 32'h0);
        tick();
        idle();
        total++; if (bus.reg_write !== 1'b0) begin bad++; $display("FAIL oor_wb_reg_write got=%b exp=0", bus.reg_write); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL oor_wb_err got=%b exp=1", bus.err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.chk_rs = 5'd2;
        bus.chk_rt = 5'd0;
        issue(5'd6);
        tick();
        issue(5'd2);
        tick();
        issue(5'd2);
        tick();
        idle();
        retire(5'd6, 1'b1, 32'h0, 32'hCAFEF00D);
        tick();
        idle();
        total++; if (bus.reg_write !== 1'b1 || bus.hazard !== 1'b1) begin
            bad++; $display("FAIL mid_pre got=%b/%b exp=1/1", bus.reg_write, bus.hazard);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.rd !== 5'd0 || bus.write_data !== 32'h0) begin
            bad++; $display("FAIL mid_rd_wdata got=%0d/%h exp=0/0", bus.rd, bus.write_data);
        end
        total++; if (bus.reg_write !== 1'b0) begin bad++; $display("FAIL mid_reg_write got=%b exp=0", bus.reg_write); end
        total++; if (bus.hazard !== 1'b0) begin bad++; $display("FAIL mid_hazard got=%b exp=0", bus.hazard); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", bus.err); end
    endtask

    initial begin
        idle();
        bus.chk_rs = 5'd0;
        bus.chk_rt = 5'd0;
        test_reset();
        test_basic();
        test_mem_select();
        test_saturation();
        test_same_cycle();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
